// File: rtl/spi_reg_bank_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_pkg
// Purpose  : Shared types and constants for the SPI register bank:
//            frame FSM state encoding, address map and command bit layout.
// Revision : 1.0 - initial release
// ============================================================================
package spi_reg_pkg;

    // Frame FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    // Address map: four read-only snapshot bytes, then control bytes
    localparam int SNAP_BASE  = 0;
    localparam int SNAP_BYTES = 4;
    localparam int CTRL_BASE  = 4;

    // Command byte layout: [7] = write, [6:0] = start address
    localparam int CMD_WR_BIT = 7;

endpackage : spi_reg_pkg
`default_nettype wire

// File: rtl/spi_reg_bank_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank_if
// Purpose  : Bundle of the signals exchanged between the SPI slave core and
//            the register bank.
// Ports    : spi_ss_n, spi_periph_slct, spi_rcv_cmd, spi_rcv_byte,
//            spi_write_sig, spi_inc_wraddr  (slave core -> bank)
//            spi_send_byte                  (bank -> slave core)
// Modports : master = SPI slave core side, slave = register bank side
// Revision : 1.0 - initial release
// ============================================================================
interface spi_reg_bank_if;
    logic       spi_ss_n;
    logic [4:0] spi_periph_slct;
    logic [7:0] spi_rcv_cmd;
    logic [7:0] spi_rcv_byte;
    logic       spi_write_sig;
    logic       spi_inc_wraddr;
    logic [7:0] spi_send_byte;

    modport master (
        output spi_ss_n, spi_periph_slct, spi_rcv_cmd, spi_rcv_byte,
               spi_write_sig, spi_inc_wraddr,
        input  spi_send_byte
    );

    modport slave (
        input  spi_ss_n, spi_periph_slct, spi_rcv_cmd, spi_rcv_byte,
               spi_write_sig, spi_inc_wraddr,
        output spi_send_byte
    );
endinterface : spi_reg_bank_if
`default_nettype wire

// File: rtl/spi_reg_bank_frame_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_frame_fsm
// Purpose  : Frame tracker for the register bank. Detects frame entry,
//            latches the command direction and start address, and steps the
//            register address on every received byte.
// Ports    : clk_i, rst_ni        clock, asynchronous active-low reset
//            ss_n_i               frame select (low = active)
//            periph_slct_i        peripheral select
//            rcv_cmd_i            command byte
//            inc_wraddr_i         end-of-byte pulse
//            state_o              current FSM state
//            cmd_wr_o             latched write flag
//            addr_o               current register address
//            start_o              frame entry this cycle (snapshot strobe)
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_fsm
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [4:0] PERIPH_ID = 5'd1
) (
    input  wire logic       clk_i,
    input  wire logic       rst_ni,
    input  wire logic       ss_n_i,
    input  wire logic [4:0] periph_slct_i,
    input  wire logic [7:0] rcv_cmd_i,
    input  wire logic       inc_wraddr_i,
    output state_t          state_o,
    output logic            cmd_wr_o,
    output logic [6:0]      addr_o,
    output logic            start_o
);

    state_t     state_q;
    logic       cmd_wr_q;
    logic [6:0] addr_q;
    // Set once ss_n has been seen high after reset, so a frame that was
    // already in progress when reset hit is not re-entered mid-stream.
    logic       armed_q;

    assign start_o = (state_q == ST_IDLE) && armed_q && !ss_n_i
                     && (periph_slct_i == PERIPH_ID);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cmd_wr_q <= 1'b0;
            addr_q   <= 7'd0;
            armed_q  <= 1'b0;
        end else begin
            if (ss_n_i) begin
                armed_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_o) begin
                        state_q <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (ss_n_i) begin
                        state_q <= ST_IDLE;
                    end else if (inc_wraddr_i) begin
                        state_q  <= ST_DATA;
                        cmd_wr_q <= rcv_cmd_i[CMD_WR_BIT];
                        addr_q   <= rcv_cmd_i[CMD_WR_BIT-1:0];
                    end
                end
                ST_DATA: begin
                    if (ss_n_i) begin
                        state_q <= ST_IDLE;
                    end else if (inc_wraddr_i) begin
                        // Wrap at the top of the map; addresses beyond the
                        // map roll naturally through 127 -> 0.
                        addr_q <= (addr_q == 7'(NUM_REGS - 1)) ? 7'd0 : addr_q + 7'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state_o  = state_q;
    assign cmd_wr_o = cmd_wr_q;
    assign addr_o   = addr_q;

endmodule : spi_frame_fsm
`default_nettype wire

// File: rtl/spi_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_reg_bank
// Purpose  : Register bank behind the SPI slave. Decodes framed read/write
//            transactions for one peripheral ID, holds the control registers,
//            freezes a 32-bit timestamp snapshot at frame start and returns
//            the addressed byte on spi_send_byte one cycle later.
// Ports    : clk_clk         system clock
//            reset_reset_n   asynchronous active-low reset
//            spi             spi_reg_bank_if.slave bundle
//            ts_value        free-running timestamp
//            ctrl_regs       control registers, address 4 in bits [7:0]
//            ctrl_wr         one-cycle pulse after a control write
// Options  : SPI_REG_BANK_ERRCNT_EN - address NUM_REGS-1 becomes a read-only
//            saturating error counter (frame aborts + dropped writes).
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_bank
    import spi_reg_pkg::*;
#(
    parameter int         NUM_REGS  = 16,
    parameter logic [4:0] PERIPH_ID = 5'd1,
    parameter logic [7:0] CTRL_RST  = 8'h00
) (
    input  wire logic                      clk_clk,
    input  wire logic                      reset_reset_n,
    spi_reg_bank_if.slave                  spi,
    input  wire logic [31:0]               ts_value,
    output logic [8*(NUM_REGS-CTRL_BASE)-1:0] ctrl_regs,
    output logic                           ctrl_wr
);

`ifdef SPI_REG_BANK_ERRCNT_EN
    localparam int NUM_CTRL = NUM_REGS - CTRL_BASE - 1;
`else
    localparam int NUM_CTRL = NUM_REGS - CTRL_BASE;
`endif

    state_t     state;
    logic       cmd_wr;
    logic [6:0] addr;
    logic       frame_start;

    logic [31:0] snap_q;
    logic [7:0]  ctrl_q [NUM_CTRL];
    logic [7:0]  ctrl_d [NUM_CTRL];
    logic        ctrl_wr_q;
    logic [7:0]  send_q;
    logic [7:0]  send_d;

    logic        data_wr;      // write pulse inside a write frame
    logic        ctrl_hit;     // address selects a writable control byte
    logic        wr_en;
    logic [7:0]  ctrl_byte;
    logic [7:0]  snap_byte;

    spi_frame_fsm #(
        .NUM_REGS  (NUM_REGS),
        .PERIPH_ID (PERIPH_ID)
    ) u_fsm (
        .clk_i         (clk_clk),
        .rst_ni        (reset_reset_n),
        .ss_n_i        (spi.spi_ss_n),
        .periph_slct_i (spi.spi_periph_slct),
        .rcv_cmd_i     (spi.spi_rcv_cmd),
        .inc_wraddr_i  (spi.spi_inc_wraddr),
        .state_o       (state),
        .cmd_wr_o      (cmd_wr),
        .addr_o        (addr),
        .start_o       (frame_start)
    );

    // The write decode uses the registered state/address, so a write that
    // coincides with inc_wraddr or with ss_n rising still lands on the
    // current address before the FSM moves on.
    assign data_wr = (state == ST_DATA) && spi.spi_write_sig && cmd_wr;

    always_comb begin
        ctrl_hit  = 1'b0;
        ctrl_byte = 8'h00;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (addr == 7'(CTRL_BASE + i)) begin
                ctrl_hit  = 1'b1;
                ctrl_byte = ctrl_q[i];
            end
        end
    end

    assign wr_en = data_wr && ctrl_hit;

    always_comb begin
        ctrl_d = ctrl_q;
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (wr_en && (addr == 7'(CTRL_BASE + i))) begin
                ctrl_d[i] = spi.spi_rcv_byte;
            end
        end
    end

    assign snap_byte = snap_q[{addr[1:0], 3'b000} +: 8];

`ifdef SPI_REG_BANK_ERRCNT_EN
    logic [7:0] errcnt_q;
    logic       err_evt;

    // Abort: frame dropped before the command byte completed.
    // Drop: write pulse in a write frame that hits no writable byte.
    assign err_evt = ((state == ST_CMD) && spi.spi_ss_n) || (data_wr && !ctrl_hit);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            errcnt_q <= 8'h00;
        end else if (err_evt && (errcnt_q != 8'hFF)) begin
            errcnt_q <= errcnt_q + 8'h01;
        end
    end
`endif

    always_comb begin
        send_d = 8'h00;
        if (state == ST_DATA) begin
            if (addr < 7'(SNAP_BASE + SNAP_BYTES)) begin
                send_d = snap_byte;
            end else if (ctrl_hit) begin
                send_d = ctrl_byte;
`ifdef SPI_REG_BANK_ERRCNT_EN
            end else if (addr == 7'(NUM_REGS - 1)) begin
                send_d = errcnt_q;
`endif
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            snap_q    <= 32'h0;
            ctrl_wr_q <= 1'b0;
            send_q    <= 8'h00;
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_q[i] <= CTRL_RST;
            end
        end else begin
            if (frame_start) begin
                snap_q <= ts_value;
            end
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= wr_en;
            send_q    <= send_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS - CTRL_BASE; g++) begin : g_ctrl_out
        if (g < NUM_CTRL) begin : g_live
            assign ctrl_regs[8*g +: 8] = ctrl_q[g];
        end else begin : g_ro
            assign ctrl_regs[8*g +: 8] = 8'h00;
        end
    end

    assign ctrl_wr           = ctrl_wr_q;
    assign spi.spi_send_byte = send_q;

endmodule : spi_reg_bank
`default_nettype wire

// File: tb/tb_spi_reg_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_reg_bank
// Purpose  : Self-checking bench for spi_reg_bank: directed frames followed
//            by randomized frames, compared against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_bank;

    localparam int         N    = 16;
    localparam logic [4:0] PID  = 5'd1;
    localparam logic [7:0] CRST = 8'h00;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [31:0]          ts;
    logic [8*(N-4)-1:0]   ctrl_regs;
    logic                 ctrl_wr;

    spi_reg_bank_if bus ();

    spi_reg_bank #(
        .NUM_REGS  (N),
        .PERIPH_ID (PID),
        .CTRL_RST  (CRST)
    ) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .spi           (bus),
        .ts_value      (ts),
        .ctrl_regs     (ctrl_regs),
        .ctrl_wr       (ctrl_wr)
    );

    always #5 clk = ~clk;

    // Model state
    logic [7:0]  m_regs [0:127];
    logic [31:0] m_snap;
    logic [7:0]  m_cnt;
    int          exp_pulses = 0;
    int          seen_pulses = 0;
    int          checks = 0;
    int          errors = 0;

    always @(negedge clk) begin
        if (ctrl_wr === 1'b1) seen_pulses++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < 128; i++) m_regs[i] = CRST;
        m_snap = 32'h0;
        m_cnt  = 8'h00;
    endfunction

    function automatic bit m_writable(input int a);
`ifdef SPI_REG_BANK_ERRCNT_EN
        return (a >= 4) && (a < N - 1);
`else
        return (a >= 4) && (a < N);
`endif
    endfunction

    function automatic int m_next(input int a);
        if (a == N - 1) return 0;
        return (a + 1) % 128;
    endfunction

    function automatic logic [7:0] m_rd(input int a);
        if (a < 4) return m_snap[8*a +: 8];
`ifdef SPI_REG_BANK_ERRCNT_EN
        if (a == N - 1) return m_cnt;
`endif
        if (a < N) return m_regs[a];
        return 8'h00;
    endfunction

    function automatic logic [8*(N-4)-1:0] m_vec();
        logic [8*(N-4)-1:0] v;
        for (int i = 4; i < N; i++) v[8*(i-4) +: 8] = m_writable(i) ? m_regs[i] : 8'h00;
        return v;
    endfunction

    function automatic void m_drop();
`ifdef SPI_REG_BANK_ERRCNT_EN
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'h01;
`endif
    endfunction

    // One complete frame: select, command byte, nb data bytes, deselect.
    task automatic run_frame(input logic [4:0] ps, input logic [7:0] cmd, input int nb,
                             input bit same_cyc, input bit end_on_write,
                             input bit use_fixed, input logic [31:0] fixed,
                             input logic [31:0] ts0, input string tag);
        int         a;
        bit         live;
        logic [7:0] d;
        live = (ps == PID);
        bus.spi_periph_slct = ps;
        ts = ts0;
        bus.spi_ss_n = 1'b0;
        step();
        if (live) m_snap = ts0;
        ts = $urandom;                      // must not leak into the snapshot
        bus.spi_rcv_cmd = cmd;
        bus.spi_inc_wraddr = 1'b1;
        step();
        bus.spi_inc_wraddr = 1'b0;
        a = int'(cmd[6:0]);
        for (int k = 0; k < nb; k++) begin
            step();
            chk($sformatf("%s_rd%0d", tag, k), bus.spi_send_byte, live ? m_rd(a) : 8'h00);
            d = use_fixed ? fixed[8*k +: 8] : 8'($urandom);
            bus.spi_rcv_byte = d;
            bus.spi_write_sig = 1'b1;
            if (same_cyc) bus.spi_inc_wraddr = 1'b1;
            if (end_on_write && (k == nb - 1)) bus.spi_ss_n = 1'b1;
            step();
            bus.spi_write_sig = 1'b0;
            bus.spi_inc_wraddr = 1'b0;
            if (live && cmd[7]) begin
                if (m_writable(a)) begin
                    m_regs[a] = d;
                    exp_pulses++;
                end else begin
                    m_drop();
                end
            end
            if (!(end_on_write && (k == nb - 1))) begin
                if (!same_cyc) begin
                    bus.spi_inc_wraddr = 1'b1;
                    step();
                    bus.spi_inc_wraddr = 1'b0;
                end
                a = m_next(a);
            end
        end
        if (!end_on_write) begin
            step();
            chk($sformatf("%s_rdend", tag), bus.spi_send_byte, live ? m_rd(a) : 8'h00);
        end
        bus.spi_ss_n = 1'b1;
        step();
        step();
        chk($sformatf("%s_idle_send", tag), bus.spi_send_byte, 8'h00);
        chk($sformatf("%s_ctrl", tag), ctrl_regs, m_vec());
        chk($sformatf("%s_pulses", tag), seen_pulses, exp_pulses);
    endtask

    initial begin
        bus.spi_ss_n = 1'b1;
        bus.spi_periph_slct = 5'd0;
        bus.spi_rcv_cmd = 8'h00;
        bus.spi_rcv_byte = 8'h00;
        bus.spi_write_sig = 1'b0;
        bus.spi_inc_wraddr = 1'b0;
        ts = 32'h0;
        m_reset();

        // Reset state
        repeat (3) step();
        chk("rst_ctrl", ctrl_regs, {(N-4){CRST}});
        chk("rst_send", bus.spi_send_byte, 8'h00);
        chk("rst_ctrl_wr", ctrl_wr, 1'b0);
        rst_n = 1'b1;
        step();
        step();

        // Write frame 0x84: A5, 3C
        run_frame(PID, 8'h84, 2, 1'b0, 1'b0, 1'b1, 32'h00003CA5, 32'hCAFE0001, "wr84");
        chk("wr84_reg4", ctrl_regs[7:0], 8'hA5);
        chk("wr84_reg5", ctrl_regs[15:8], 8'h3C);
        chk("wr84_npulse", seen_pulses, 2);

        // Snapshot readout; ts changes mid-frame inside run_frame
        run_frame(PID, 8'h00, 4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h12345678, "rdsnap");

        // Write starting at 15, wrapping into read-only 0 and 1
        run_frame(PID, 8'h8F, 3, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, "wr8F");
        run_frame(PID, 8'h04, 1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, "rd4");
        chk("rd4_unchanged", ctrl_regs[7:0], 8'hA5);

        // Wrong peripheral ID
        run_frame(5'd2, 8'h84, 1, 1'b0, 1'b0, 1'b1, 32'h000000FF, $urandom, "ps2");
        chk("ps2_reg4", ctrl_regs[7:0], 8'hA5);

        // ss_n rising with the last write pulse; write + inc in one cycle
        run_frame(PID, 8'h86, 2, 1'b0, 1'b1, 1'b0, 32'h0, $urandom, "endwr");
        run_frame(PID, 8'h87, 3, 1'b1, 1'b0, 1'b0, 32'h0, $urandom, "samecyc");

        // Randomized frames
        for (int r = 0; r < 40; r++) begin
            logic [4:0] ps;
            ps = ($urandom_range(0, 7) == 0) ? 5'd2 : PID;
            run_frame(ps, 8'($urandom), int'($urandom_range(1, 5)),
                      1'($urandom), 1'($urandom), 1'b0, 32'h0, $urandom,
                      $sformatf("rnd%0d", r));
        end

        // Reset in the middle of a write frame
        bus.spi_periph_slct = PID;
        bus.spi_ss_n = 1'b0;
        ts = $urandom;
        step();
        bus.spi_rcv_cmd = 8'h84;
        bus.spi_inc_wraddr = 1'b1;
        step();
        bus.spi_inc_wraddr = 1'b0;
        bus.spi_rcv_byte = 8'h99;
        bus.spi_write_sig = 1'b1;
        step();
        bus.spi_write_sig = 1'b0;
        m_regs[4] = 8'h99;
        exp_pulses++;
        step();
        chk("mid_reg4", ctrl_regs[7:0], 8'h99);
        rst_n = 1'b0;
        m_reset();
        #2;
        chk("mid_rst_ctrl", ctrl_regs, m_vec());
        chk("mid_rst_send", bus.spi_send_byte, 8'h00);
        step();
        rst_n = 1'b1;
        // ss_n still low: the bank must wait for a fresh frame
        step();
        bus.spi_rcv_byte = 8'h55;
        bus.spi_inc_wraddr = 1'b1;
        step();
        bus.spi_inc_wraddr = 1'b0;
        bus.spi_write_sig = 1'b1;
        step();
        bus.spi_write_sig = 1'b0;
        step();
        chk("post_rst_ctrl", ctrl_regs, m_vec());
        chk("post_rst_send", bus.spi_send_byte, 8'h00);
        chk("post_rst_pulses", seen_pulses, exp_pulses);
        bus.spi_ss_n = 1'b1;
        step();
        step();
        run_frame(PID, 8'h85, 2, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, "post_rst_wr");

`ifdef SPI_REG_BANK_ERRCNT_EN
        // Abort during CMD, then a write to read-only address 2
        bus.spi_periph_slct = PID;
        bus.spi_ss_n = 1'b0;
        step();
        bus.spi_ss_n = 1'b1;
        step();
        step();
        m_drop();
        run_frame(PID, 8'h82, 1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, "err_wr2");
        run_frame(PID, 8'h0F, 1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom, "err_rd");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_spi_reg_bank
`default_nettype wire
